mem_arbiter: RTL and testbench

Shares the single-port unified memory between the instruction-fetch path and the load/store path of the multicycle CPU. Each requester uses a req/ack handshake. The block sequences each memory access through a small FSM with a configurable wait-state count. It also handles byte-lane steering for LB/SB. It sits between the control FSM (fetch and memory states) and the memory model.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_byte_lane.sv | 46 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t    REQ_IF  = 1'b0;
  localparam req_id_t    REQ_D   = 1'b1;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter_byte_lane.sv
// Byte-lane steering: store byte enables / replicated store data, and
// sign-extended byte extraction for loads. Purely combinational.
module byte_lane
  import mem_arb_pkg::*;
(
  input  logic        st_byte,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic        ld_byte,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] sext8(input logic signed [7:0] b);
    logic signed [31:0] w;
    w = b;
    return w;
  endfunction

  logic [7:0] ld_sel;

  // Store side: a byte goes to every lane, only the addressed lane is enabled.
  always_comb begin
    st_be    = BE_WORD;
    st_wdata = st_data;
    if (st_byte) begin
      st_be    = 4'b0001 << st_lane;
      st_wdata = {4{st_data[7:0]}};
    end
  end

  // Load side: pick the addressed lane and sign-extend it for byte loads.
  always_comb begin
    case (ld_lane)
      2'd0:    ld_sel = ld_word[7:0];
      2'd1:    ld_sel = ld_word[15:8];
      2'd2:    ld_sel = ld_word[23:16];
      default: ld_sel = ld_word[31:24];
    endcase
    ld_data = ld_byte ? sext8(ld_sel) : ld_word;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// load/store. Round-robin on ties, WAIT_CYCLES extra cycles per access,
// one-cycle ack pulse per completed transfer.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  req_id_t    last_grant;
  req_id_t    gnt_id;
  logic [1:0] lat_lane;
  logic       lat_byte;
  logic       lat_we;
  logic       lat_err;

  req_id_t           sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_byte;
  logic              sel_err;
  logic [DATA_W-1:0] sel_wdata;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  // Pick the requester to grant and mux its request fields.
  always_comb begin
    if (if_req && d_req) sel_id = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
    else if (if_req)     sel_id = REQ_IF;
    else                 sel_id = REQ_D;
    sel_addr  = if_addr;
    sel_we    = 1'b0;
    sel_byte  = 1'b0;
    sel_err   = 1'b0;
    sel_wdata = '0;
    if (sel_id == REQ_D) begin
      sel_addr  = d_addr;
      sel_we    = d_we;
      sel_byte  = d_byte;
      sel_wdata = d_wdata;
      sel_err   = !d_byte && (d_addr[1:0] != 2'b00);
    end
  end

  // Store steering uses the incoming request so mem_* can be registered at
  // grant time; load steering uses the latched lane against mem_rdata.
  byte_lane u_lane (
    .st_byte  (sel_byte),
    .st_lane  (sel_addr[1:0]),
    .st_data  (sel_wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_byte  (lat_byte),
    .ld_lane  (lat_lane),
    .ld_word  (mem_rdata),
    .ld_data  (ld_data)
  );

  // Access sequencer: IDLE grants, ACCESS drives memory, RESP pulses ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= REQ_D;
      gnt_id     <= REQ_IF;
      lat_lane   <= '0;
      lat_byte   <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            gnt_id    <= sel_id;
            lat_lane  <= sel_addr[1:0];
            lat_byte  <= sel_byte;
            lat_we    <= sel_we;
            lat_err   <= sel_err;
            cnt       <= WAIT_INIT;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_be    <= st_be;
            mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= st_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= '0;
            state  <= RESP;
            if (gnt_id == REQ_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_ack <= 1'b1;
              d_err <= lat_err;
              if (!lat_we) d_rdata <= ld_data;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if_ack     <= 1'b0;
          d_ack      <= 1'b0;
          d_err      <= 1'b0;
          last_grant <= gnt_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory accesses
// and acks; a negedge monitor pops and compares as the DUT presents them.
module tb_mem_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int WAIT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req, d_we, d_byte;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack, d_err;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          is_d;
    bit          upd;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    bit          cb;
    logic [3:0]  be;
    bit          cw;
    logic [31:0] wdata;
  } macc_t;

  resp_t rq[$];
  macc_t mq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d  = '0;
  int          en_len = 0;
  logic        en_prev = 1'b0;
  macc_t       cur_m;
  resp_t       cur_r;

  always @(negedge clk) begin
    if (rst) begin
      exp_if  = '0;
      exp_d   = '0;
      en_len  = 0;
      en_prev = 1'b0;
    end else begin
      if (mem_en) begin
        if (!en_prev) begin
          if (mq.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
          else cur_m = mq.pop_front();
        end
        chk("mem_addr", mem_addr, cur_m.addr);
        chk("mem_we", 32'(mem_we), 32'(cur_m.we));
        if (cur_m.cb) chk("mem_be", 32'(mem_be), 32'(cur_m.be));
        if (cur_m.cw) chk("mem_wdata", mem_wdata, cur_m.wdata);
        en_len++;
      end else if (en_prev) begin
        chk("mem_en_len", 32'(en_len), 32'(WAIT_CYCLES + 1));
        en_len = 0;
      end
      en_prev = mem_en;

      if (if_ack || d_ack) begin
        ack_seen++;
        chk("ack_onehot", 32'(if_ack && d_ack), 32'd0);
        if (rq.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
        else begin
          cur_r = rq.pop_front();
          chk("ack_who", 32'(d_ack), 32'(cur_r.is_d));
          if (cur_r.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(cur_r.cyc));
          if (cur_r.upd) begin
            if (cur_r.is_d) exp_d = cur_r.rdata;
            else            exp_if = cur_r.rdata;
          end
          if (d_ack) chk("d_err", 32'(d_err), 32'(cur_r.err));
        end
      end
      if (!d_ack) chk("d_err_idle", 32'(d_err), 32'd0);
      chk("if_rdata", if_rdata, exp_if);
      chk("d_rdata", d_rdata, exp_d);
    end
  end

  task automatic wait_ack(input bit is_d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_ack : if_ack) && n < 40);
    if (n >= 40) chk("ack_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] word);
    resp_t r;
    macc_t m;
    @(posedge clk); #1;
    mem_rdata = word;
    if_addr   = a;
    if_req    = 1'b1;
    m.addr = {a[31:2], 2'b00}; m.we = 1'b0; m.cb = 1'b1; m.be = 4'hF; m.cw = 1'b0; m.wdata = '0;
    r.is_d = 1'b0; r.upd = 1'b1; r.rdata = word; r.err = 1'b0; r.cyc = cyc + 2 + WAIT_CYCLES;
    mq.push_back(m);
    rq.push_back(r);
    wait_ack(1'b0);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input bit byt, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word,
                         input bit upd, input logic [31:0] exp_rd,
                         input bit cb, input logic [3:0] be,
                         input logic [31:0] mwd, input bit err);
    resp_t r;
    macc_t m;
    @(posedge clk); #1;
    mem_rdata = word;
    d_we = we; d_byte = byt; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    m.addr = {a[31:2], 2'b00}; m.we = we; m.cb = cb; m.be = be; m.cw = we; m.wdata = mwd;
    r.is_d = 1'b1; r.upd = upd; r.rdata = exp_rd; r.err = err; r.cyc = cyc + 2 + WAIT_CYCLES;
    mq.push_back(m);
    rq.push_back(r);
    wait_ack(1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    resp_t r;
    macc_t m;
    int    c;
    int    seen;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", 32'({if_ack, d_ack, d_err}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // fetch, then SB / LB / LB / misaligned LW / SW
    do_fetch(32'h0000_3002, 32'h2408_000A);
    do_data(1'b1, 1'b1, 32'h0000_1003, 32'h0000_00A5, 32'hDEAD_BEEF,
            1'b0, 32'h0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0);
    do_data(1'b0, 1'b1, 32'h0000_1002, 32'h0, 32'h12F4_3456,
            1'b1, 32'hFFFF_FFF4, 1'b0, 4'b0000, 32'h0, 1'b0);
    do_data(1'b0, 1'b1, 32'h0000_1002, 32'h0, 32'h1274_3456,
            1'b1, 32'h0000_0074, 1'b0, 4'b0000, 32'h0, 1'b0);
    do_data(1'b0, 1'b0, 32'h0000_1006, 32'h0, 32'h1122_3344,
            1'b1, 32'h1122_3344, 1'b1, 4'b1111, 32'h0, 1'b1);
    do_data(1'b1, 1'b0, 32'h0000_1008, 32'hCAFE_F00D, 32'h0,
            1'b0, 32'h0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0);
    do_fetch(32'h0000_0040, 32'h0BAD_CAFE);

    // reset during the second ACCESS cycle of a word store
    @(posedge clk); #1;
    d_we = 1'b1; d_byte = 1'b0; d_addr = 32'h0000_2000; d_wdata = 32'h0000_0055;
    d_req = 1'b1;
    m.addr = 32'h0000_2000; m.we = 1'b1; m.cb = 1'b1; m.be = 4'hF; m.cw = 1'b1; m.wdata = 32'h55;
    mq.push_back(m);
    @(posedge clk);
    @(posedge clk); #2;
    chk("abort_pre_mem_en", 32'(mem_en), 32'd1);
    seen = ack_seen;
    rst = 1'b1;
    #1;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_d_ack", 32'(d_ack), 32'd0);
    d_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_ack", 32'(ack_seen), 32'(seen));
    chk("abort_idle_mem_en", 32'(mem_en), 32'd0);

    // tie after reset: fetch, data, fetch, data
    for (int k = 0; k < 2; k++) begin
      m.addr = 32'h0000_0100; m.we = 1'b0; m.cb = 1'b1; m.be = 4'hF; m.cw = 1'b0; m.wdata = '0;
      mq.push_back(m);
      r.is_d = 1'b0; r.upd = 1'b1; r.rdata = 32'h600D_F00D; r.err = 1'b0; r.cyc = -1;
      rq.push_back(r);
      m.addr = 32'h0000_0200;
      mq.push_back(m);
      r.is_d = 1'b1;
      rq.push_back(r);
    end
    @(posedge clk); #1;
    mem_rdata = 32'h600D_F00D;
    if_addr = 32'h0000_0100;
    d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_0200;
    c = cyc;
    fork
      begin
        if_req = 1'b1;
        for (int n = 0; n < 2; n++) begin
          wait_ack(1'b0);
          @(posedge clk); #1;
        end
        if_req = 1'b0;
      end
      begin
        d_req = 1'b1;
        for (int n = 0; n < 2; n++) begin
          wait_ack(1'b1);
          @(posedge clk); #1;
        end
        d_req = 1'b0;
      end
    join
    chk("tie_span", 32'(cyc - c), 32'(4 * (WAIT_CYCLES + 3)));

    do_fetch(32'h0000_0044, 32'h1357_9BDF);

    repeat (5) @(negedge clk);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("mem_queue_empty", 32'(mq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
